// File: rtl/gate_op_scheduler_pkg.sv
// Shared definitions for the gate-op scheduler: opcode encodings, FSM states
// and the opcode legality helper.
package gate_op_pkg;

  localparam int OP_W = 3;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_NOT  = 3'd0;
  localparam op_t OP_AND  = 3'd1;
  localparam op_t OP_XOR  = 3'd2;
  localparam op_t OP_NAND = 3'd3;
  localparam op_t OP_NOR  = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic op_legal(op_t op);
    return op <= OP_NOR;
  endfunction

endpackage

// File: rtl/gate_op_scheduler_if.sv
// Request/response bundle between the requesters, the consumer and the scheduler.
interface gate_op_scheduler_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [3*N_REQ-1:0]     req_op;
  logic [WIDTH*N_REQ-1:0] req_a;
  logic [WIDTH*N_REQ-1:0] req_b;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [WIDTH-1:0]       rsp_data;
  logic                   rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface

// File: rtl/gate_op_scheduler_gate_cell_mux.sv
// The shared 1-bit gate resource: one gate per opcode and an output mux.
module gate_cell_mux
  import gate_op_pkg::*;
(
  input  op_t  op,
  input  logic a,
  input  logic b,
  output logic y
);

  logic y_not, y_and, y_xor, y_nand, y_nor;

  assign y_not  = ~a;
  assign y_and  = a & b;
  assign y_xor  = a ^ b;
  assign y_nand = ~(a & b);
  assign y_nor  = ~(a | b);

  always_comb begin
    // NOTE: default assignment first so every path drives y and no latch is inferred.
    y = 1'b0;
    case (op)
      OP_NOT:  y = y_not;
      OP_AND:  y = y_and;
      OP_XOR:  y = y_xor;
      OP_NAND: y = y_nand;
      OP_NOR:  y = y_nor;
      default: y = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_op_scheduler.sv
// Round-robin scheduler that runs each granted WIDTH-bit operation bit-serially
// through a single shared gate cell and returns the result with a handshake.
module gate_op_scheduler
  import gate_op_pkg::*;
#(
  parameter int  N_REQ = 4,
  parameter int  WIDTH = 8,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input logic               clk,
  input logic               rst_n,
  gate_op_scheduler_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state_q;
  logic [ID_W-1:0]  rr_ptr_q, id_q;
  op_t              op_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, rsp_data_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rsp_valid_q, rsp_err_q;

  logic             grant_any;
  logic [ID_W-1:0]  grant_id, next_ptr;
  op_t              grant_op;
  logic [WIDTH-1:0] grant_a, grant_b, res_d;
  logic             cell_y;

  function automatic logic [ID_W-1:0] wrap_add(logic [ID_W-1:0] base, int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return ID_W'(s);
  endfunction

  // Scan offsets high to low so the lowest offset from rr_ptr wins.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[wrap_add(rr_ptr_q, k)]) begin
        grant_any = 1'b1;
        grant_id  = wrap_add(rr_ptr_q, k);
      end
    end
    next_ptr = wrap_add(grant_id, 1);
    grant_op = bus.req_op[OP_W*int'(grant_id) +: OP_W];
    grant_a  = bus.req_a[WIDTH*int'(grant_id) +: WIDTH];
    grant_b  = bus.req_b[WIDTH*int'(grant_id) +: WIDTH];

    bus.req_ready = '0;
    if (state_q == IDLE && grant_any) bus.req_ready[grant_id] = 1'b1;
  end

  gate_cell_mux u_cell (
    .op (op_q),
    .a  (a_q[0]),
    .b  (b_q[0]),
    .y  (cell_y)
  );

  assign res_d = (res_q >> 1) | (WIDTH'(cell_y) << (WIDTH - 1));

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      op_q        <= OP_NOT;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_any) begin
            op_q     <= grant_op;
            a_q      <= grant_a;
            b_q      <= grant_b;
            id_q     <= grant_id;
            cnt_q    <= '0;
            rr_ptr_q <= next_ptr;
            if (op_legal(grant_op)) begin
              state_q <= RUN;
            end else begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= '0;
            end
          end
        end
        RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          res_q <= res_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= res_d;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: doc/gate_op_scheduler.md
Name: gate_op_scheduler

Overview:
- Time-shares one 1-bit gate cell between N_REQ requesters.
- The cell implements NOT, AND, XOR, NAND or NOR, selected by opcode.
- Each requester submits a WIDTH-bit bitwise operation. A round-robin arbiter grants one request at a time, and the operation runs bit-serially through the shared cell, one bit per cycle.
- Sits between the extraction-test request generators and the shared gate resource; exercises FSM, counter and shift-register extraction in flows.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, operand/result width in bits (1..32)
- ID_W, $clog2(N_REQ), width of requester index (derived, not overridden)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  N_REQ  per-requester request pending
- req_ready  out  N_REQ  one-hot accept pulse
- req_op  in  3*N_REQ  opcode for requester i at [3i+2:3i]
- req_a  in  WIDTH*N_REQ  operand A, slice i
- req_b  in  WIDTH*N_REQ  operand B, slice i (ignored for NOT)
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  ID_W  index of granted requester
- rsp_data  out  WIDTH  result
- rsp_err  out  1  illegal opcode flag

Behaviour:
- Opcodes:
  - 0 NOT(A)
  - 1 AND
  - 2 XOR
  - 3 NAND
  - 4 NOR
  - 5..7 illegal
- Reset (async assert, sync release):
  - state=IDLE; rr_ptr=0.
  - All outputs 0: req_ready, rsp_valid, rsp_id, rsp_data, rsp_err.
- States: IDLE, RUN, RESP.
- IDLE:
  - If any req_valid, grant g = first set bit scanning from rr_ptr upward with wrap.
  - req_ready[g]=1 for exactly this cycle (combinational from state/valid/rr_ptr); the transfer happens on this edge.
  - Latch op, A, B, id=g; bit counter=0; rr_ptr <= g+1 mod N_REQ.
  - Next state: RUN if op legal, else RESP with rsp_err=1 and rsp_data=0.
  - No req_valid: stay in IDLE, all req_ready=0.
- RUN:
  - Each cycle, gate cell computes f(a_sh[0], b_sh[0]).
  - A and B shift right by 1; the result shifts in at MSB of res_sh.
  - Counter increments. When counter==WIDTH-1, the shift completes and the next state is RESP.
  - After WIDTH RUN cycles, res_sh[i] = f(A[i],B[i]).
- RESP:
  - rsp_valid=1; rsp_id, rsp_data, rsp_err are stable until handshake.
  - rsp_valid&&rsp_ready → IDLE; rsp_valid deasserts the next cycle.
  - No new grants while in RESP or RUN (req_ready=0).
- Latency: accept edge at cycle t → rsp_valid high in cycle t+WIDTH+1 (illegal op: t+1).
- Throughput: one op per WIDTH+2 cycles with rsp_ready tied high.
- Fairness: a continuously asserting requester is served at most once per N_REQ grants when others are waiting.
- Requester dropping req_valid without req_ready: legal, no effect.
- Operand changes after accept: no effect (latched).
- rsp_ready high outside RESP: ignored.
- Reset mid-RUN/RESP: op discarded, no response issued, rr_ptr back to 0.

Decomposition:
- Package gate_op_pkg holds:
  - Opcode localparams OP_NOT..OP_NOR
  - Opcode width (3)
  - State encoding (IDLE=0, RUN=1, RESP=2)
  - Function op_legal(op)
- Sub-module gate_cell_mux: combinational 1-bit unit with ports op, a, b, y, one gate per opcode plus output mux. It is the shared resource; the scheduler instantiates exactly one.
- Round-robin pick stays inline in the scheduler.

Test Plan:
- Single XOR:
  - Stimulus: requester 1 sends op=2, A=8'hA5, B=8'h0F.
  - Response: req_ready[1] pulse; rsp_valid 9 cycles later; rsp_id=1, rsp_data=8'hAA, rsp_err=0.
- All opcodes:
  - Stimulus: requester 0 with A=8'hC3, B=8'h5A.
  - Response: NOT→3C, AND→42, XOR→99, NAND→BD, NOR→24.
- Round robin:
  - Stimulus: all 4 req_valid held high, rsp_ready=1.
  - Response: grant order 0,1,2,3,0; each grant WIDTH+2=10 cycles apart.
- Backpressure:
  - Stimulus: rsp_ready low 5 cycles during RESP.
  - Response: rsp_valid/data/id stable; no req_ready pulse; IDLE one cycle after handshake.
- Illegal op:
  - Stimulus: op=6 from requester 2.
  - Response: rsp_valid the cycle after accept; rsp_err=1, rsp_data=0, rsp_id=2.
- Reset mid-RUN:
  - Stimulus: assert rst_n=0 at bit 3 of an AND.
  - Response: outputs 0 immediately; after release, requesters 0 and 3 valid → requester 0 granted first.
